rb_ctrl: RTL and testbench

RB_CTRL -- requirements
Module: rb_ctrl

---
 rtl/rb_if.sv | 30 +++
 rtl/rb_ctrl.sv | 92 +++++++++
 tb/tb_rb_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rb_if.sv
// Row-buffer controller handshake: frame start, pixel stream, BRAM control
// and window-column qualifiers.
interface rb_if #(
  parameter int K          = 3,
  parameter int ADDR_WIDTH = 9
);
  logic                  start;
  logic                  pix_valid;
  logic                  pix_ready;
  logic [K-2:0]          bram_we;
  logic [ADDR_WIDTH-1:0] bram_waddr;
  logic [ADDR_WIDTH-1:0] bram_raddr;
  logic [2:0]            rd_base;
  logic                  win_valid;
  logic                  win_last;
  logic                  busy;
  logic                  complete;

  modport slave (
    input  start, pix_valid,
    output pix_ready, bram_we, bram_waddr, bram_raddr, rd_base,
           win_valid, win_last, busy, complete
  );

  modport master (
    output start, pix_valid,
    input  pix_ready, bram_we, bram_waddr, bram_raddr, rd_base,
           win_valid, win_last, busy, complete
  );
endinterface

// File: rtl/rb_ctrl.sv
// Line-buffer controller for a KxK sliding window: rotates K-1 BRAM row
// buffers, generates shared read/write column address and window qualifiers.
module rb_ctrl #(
  parameter int IMG_W      = 512,
  parameter int IMG_H      = 512,
  parameter int K          = 3,
  parameter int ADDR_WIDTH = 9
) (
  input logic clk,
  input logic rst,
  rb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(IMG_W - 1);
  localparam logic [ADDR_WIDTH-1:0] COL_K   = ADDR_WIDTH'(K - 1);
  localparam logic [ROW_W-1:0]      ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [ROW_W-1:0]      ROW_FIL = ROW_W'(K - 2);
  localparam logic [2:0]            SEL_MAX = 3'(K - 2);

  state_t                state, nxt;
  logic [ADDR_WIDTH-1:0] col;
  logic [ROW_W-1:0]      row;
  logic [2:0]            wr_sel;
  logic                  win_valid, win_last;
  logic                  acc, last_col, last_row, run;

  assign run      = (state == RUN);
  assign acc      = bus.pix_valid && bus.pix_ready;
  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);

  assign bus.pix_ready  = (state == FILL) || run;
  assign bus.busy       = (state != IDLE);
  assign bus.complete   = (state == DONE);
  assign bus.bram_waddr = col;
  assign bus.bram_raddr = col;
  assign bus.rd_base    = run ? wr_sel : 3'd0;
  assign bus.win_valid  = win_valid;
  assign bus.win_last   = win_last;

  always_comb begin
    bus.bram_we = '0;
    for (int i = 0; i < K - 1; i++)
      bus.bram_we[i] = acc && (wr_sel == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (bus.start) nxt = FILL;
      FILL: if (acc && last_col && row == ROW_FIL) nxt = RUN;
      RUN:  if (acc && last_col && last_row) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Counters only move on accepted pixels; frame end leaves them zeroed for the next start.
  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      wr_sel    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else begin
      win_valid <= acc && run && (col >= COL_K);
      win_last  <= acc && run && last_col && last_row;
      if (acc) begin
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row    <= '0;
            wr_sel <= '0;
          end else begin
            row    <= row + 1'b1;
            wr_sel <= (wr_sel == SEL_MAX) ? 3'd0 : wr_sel + 3'd1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rb_ctrl.sv
// Directed bench for rb_ctrl at 8x6 image, K=3: full, stalled and aborted frames.
module tb_rb_ctrl;
  localparam int W = 8, H = 6, KK = 3, AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, errors = 0;
  int   nwin = 0, nlast = 0, ncomp = 0;
  int   b_win, b_last, b_comp;

  rb_if #(.K(KK), .ADDR_WIDTH(AW)) bus ();

  rb_ctrl #(.IMG_W(W), .IMG_H(H), .K(KK), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.win_valid) nwin  <= nwin + 1;
      if (bus.win_last)  nlast <= nlast + 1;
      if (bus.complete)  ncomp <= ncomp + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, "_rdy"},  int'(bus.pix_ready), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_we"},   int'(bus.bram_we), 0);
    chk({tag, "_wa"},   int'(bus.bram_waddr), 0);
    chk({tag, "_ra"},   int'(bus.bram_raddr), 0);
    chk({tag, "_base"}, int'(bus.rd_base), 0);
    chk({tag, "_cmp"},  int'(bus.complete), 0);
  endtask

  // Runs pixels 0..npix-1 of a frame; gap inserts one idle cycle after each pixel.
  task automatic frame(input bit gap, input int npix, input int start_at);
    int r, c;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    chk("start_busy", int'(bus.busy), 1);
    for (int p = 0; p < npix; p++) begin
      r = p / W;
      c = p % W;
      bus.pix_valid = 1'b1;
      bus.start     = (p == start_at);
      #1;
      chk("rdy",  int'(bus.pix_ready), 1);
      chk("wa",   int'(bus.bram_waddr), c);
      chk("ra",   int'(bus.bram_raddr), c);
      chk("we",   int'(bus.bram_we), 1 << (r % 2));
      chk("base", int'(bus.rd_base), (r >= 2) ? (r % 2) : 0);
      cyc();
      bus.start = 1'b0;
      chk("wv", int'(bus.win_valid), (r >= 2 && c >= 2) ? 1 : 0);
      chk("wl", int'(bus.win_last), (p == W*H-1) ? 1 : 0);
      if (gap && p != W*H-1) begin
        bus.pix_valid = 1'b0;
        #1;
        chk("gap_we", int'(bus.bram_we), 0);
        chk("gap_wa", int'(bus.bram_waddr), (p + 1) % W);
        cyc();
        chk("gap_wv", int'(bus.win_valid), 0);
        chk("gap_wl", int'(bus.win_last), 0);
        chk("gap_cmp", int'(bus.complete), 0);
      end
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic snap();
    b_win  = nwin;
    b_last = nlast;
    b_comp = ncomp;
  endtask

  task automatic totals(input string tag, input int wins, input int comps);
    chk({tag, "_nwin"},  nwin - b_win, wins);
    chk({tag, "_nlast"}, nlast - b_last, comps);
    chk({tag, "_ncomp"}, ncomp - b_comp, comps);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    rst = 1'b1;
    repeat (3) cyc();
    idle_outs("rst");
    chk("rst_wv", int'(bus.win_valid), 0);
    chk("rst_wl", int'(bus.win_last), 0);
    rst = 1'b0;
    cyc();

    // back-to-back frame, with a stray start pulse during RUN
    snap();
    frame(1'b0, W*H, 30);
    chk("done_cmp", int'(bus.complete), 1);
    chk("done_rdy", int'(bus.pix_ready), 0);
    bus.start = 1'b1;               // start in DONE must be ignored
    cyc();
    bus.start = 1'b0;
    chk("post_cmp", int'(bus.complete), 0);
    chk("post_busy", int'(bus.busy), 0);
    cyc();
    chk("post2_busy", int'(bus.busy), 0);
    totals("f1", (H-KK+1)*(W-KK+1), 1);

    // pixels offered in IDLE are dropped
    bus.pix_valid = 1'b1;
    repeat (5) begin
      cyc();
      idle_outs("idlepix");
    end
    bus.pix_valid = 1'b0;

    // stalled frame
    snap();
    frame(1'b1, W*H, -1);
    chk("g_done_cmp", int'(bus.complete), 1);
    cyc();
    chk("g_post_busy", int'(bus.busy), 0);
    totals("f2", (H-KK+1)*(W-KK+1), 1);

    // abort after pixel 20, reset wins over start and pix_valid
    frame(1'b0, 21, -1);
    snap();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.pix_valid = 1'b1;
    cyc();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pix_valid = 1'b0;
    idle_outs("abort");
    repeat (3) cyc();
    totals("abort", 0, 0);
    chk("abort_busy", int'(bus.busy), 0);

    snap();
    frame(1'b0, W*H, -1);
    chk("f3_done_cmp", int'(bus.complete), 1);
    cyc();
    chk("f3_post_busy", int'(bus.busy), 0);
    totals("f3", (H-KK+1)*(W-KK+1), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
